// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_e;

    localparam int DEF_WIDTH = 32;

    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int CNT_W = cnt_w(DEF_WIDTH);

endpackage

// File: rtl/muldiv_iter_dp.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract-shift for divide.
module muldiv_iter_dp #(
    parameter int WIDTH = 32
) (
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             ge;

    assign sum     = {1'b0, rem_i} + {1'b0, (q_i[0] ? b_i : {WIDTH{1'b0}})};
    assign shifted = {rem_i, q_i[WIDTH-1]};
    // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
    assign diff    = shifted[WIDTH-1:0] - b_i;
    assign ge      = (shifted >= {1'b0, b_i});

    always_comb begin
        rem_o = rem_i;
        q_o   = q_i;
        if (is_div_i) begin
            rem_o = ge ? diff : shifted[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], ge};
        end else begin
            rem_o = sum[WIDTH:1];
            q_o   = {sum[0], q_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative mult/div sequencer with HI/LO registers and EX-stage stall generation.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             stall
);

    localparam int CW = cnt_w(WIDTH);

    state_e           state_q;
    op_e              op_q;
    logic [CW-1:0]    cnt_q;
    logic             neg_q;
    logic             rneg_q;
    logic             busy_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] q_d;

    logic             start;
    logic             accept;
    logic             div_zero;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0] res_hi_d;
    logic [WIDTH-1:0] res_lo_d;

    assign start    = start_mult | start_div;
    assign accept   = (state_q == IDLE) & start & ~flush;
    assign div_zero = ~start_mult & start_div & (op_b == '0);
    assign a_neg    = is_signed & op_a[WIDTH-1];
    assign b_neg    = is_signed & op_b[WIDTH-1];
    assign abs_a    = a_neg ? -op_a : op_a;
    assign abs_b    = b_neg ? -op_b : op_b;

    muldiv_iter_dp #(.WIDTH(WIDTH)) u_dp (
        .is_div_i (op_q == OP_DIV),
        .rem_i    (rem_q),
        .q_i      (q_q),
        .b_i      (b_q),
        .rem_o    (rem_d),
        .q_o      (q_d)
    );

    assign prod     = {rem_q, q_q};
    assign prod_fix = neg_q ? -prod : prod;

    always_comb begin
        res_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        res_lo_d = prod_fix[WIDTH-1:0];
        if (op_q == OP_DIV) begin
            // Divide-by-zero arrives here with both sign flags clear, so HI/LO pass raw.
            res_hi_d = rneg_q ? -rem_q : rem_q;
            res_lo_d = neg_q ? -q_q : q_q;
        end
    end

    // Working registers carry no reset: they are always loaded before use.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (start_mult) begin
                rem_q <= '0;
                q_q   <= abs_b;
                b_q   <= abs_a;
            end else if (div_zero) begin
                rem_q <= op_a;
                q_q   <= '1;
                b_q   <= op_b;
            end else begin
                rem_q <= '0;
                q_q   <= abs_a;
                b_q   <= abs_b;
            end
        end else if (state_q == CALC) begin
            rem_q <= rem_d;
            q_q   <= q_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            busy_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q   <= start_mult ? OP_MUL : OP_DIV;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        if (div_zero) begin
                            neg_q   <= 1'b0;
                            rneg_q  <= 1'b0;
                            state_q <= FIX;
                        end else begin
                            neg_q   <= a_neg ^ b_neg;
                            rneg_q  <= ~start_mult & a_neg;
                            state_q <= CALC;
                        end
                    end else begin
                        if (wr_hi) hi_q <= wr_data;
                        if (wr_lo) lo_q <= wr_data;
                    end
                end
                CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_q <= FIX;
                end
                FIX: begin
                    hi_q    <= res_hi_d;
                    lo_q    <= res_lo_d;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign stall = busy_q & (start_mult | start_div | rd_hilo | wr_hi | wr_lo);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: directed plan cases plus random mult/div traffic.
module tb_muldiv_sequencer;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_mult, start_div, is_signed;
    logic [31:0] op_a, op_b;
    logic        flush, rd_hilo, wr_hi, wr_lo;
    logic [31:0] wr_data;
    logic [31:0] hi, lo;
    logic        busy, stall;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_mult (start_mult),
        .start_div  (start_div),
        .is_signed  (is_signed),
        .op_a       (op_a),
        .op_b       (op_b),
        .flush      (flush),
        .rd_hilo    (rd_hilo),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wr_data    (wr_data),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .stall      (stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input bit mul, input bit sgn,
                                          input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, qq, rr;
        logic [63:0] r;
        sa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
        if (mul) begin
            r = sa * sb;
        end else if (b == 32'd0) begin
            r = {a, 32'hFFFF_FFFF};
        end else begin
            qq = sa / sb;
            rr = sa % sb;
            r  = {rr[31:0], qq[31:0]};
        end
        return r;
    endfunction

    // Drives one start for a single cycle; returns at the negedge right after the sampling edge.
    task automatic issue(input bit mul, input bit both, input bit sgn,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic [31:0] ecyc);
        exp_t e;
        @(negedge clk);
        start_mult = mul;
        start_div  = !mul || both;
        is_signed  = sgn;
        op_a       = a;
        op_b       = b;
        #1;
        chk("start_not_stalled", {63'b0, stall}, 64'd0);
        if (push) begin
            e.hi = ehi; e.lo = elo; e.cyc = ecyc;
            sb_q.push_back(e);
        end
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
    endtask

    task automatic retire(input string tag);
        logic [31:0] cyc;
        exp_t e;
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_busy_cycles"}, {32'b0, cyc}, {32'b0, e.cyc});
            chk({tag, "_hi"}, {32'b0, hi}, {32'b0, e.hi});
            chk({tag, "_lo"}, {32'b0, lo}, {32'b0, e.lo});
        end
    endtask

    task automatic run(input string tag, input bit mul, input bit sgn,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] ehi, input logic [31:0] elo, input logic [31:0] ecyc);
        issue(mul, 1'b0, sgn, a, b, 1'b1, ehi, elo, ecyc);
        retire(tag);
    endtask

    task automatic load_hilo(input logic [31:0] h, input logic [31:0] l);
        @(negedge clk);
        wr_hi = 1'b1; wr_data = h;
        @(negedge clk);
        wr_hi = 1'b0; wr_lo = 1'b1; wr_data = l;
        @(negedge clk);
        wr_lo = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] cyc;
        logic [63:0] m;
        exp_t e;
        bit mul, sgn;
        logic [31:0] a, b;

        rst_n = 1'b0; start_mult = 1'b0; start_div = 1'b0; is_signed = 1'b0;
        op_a = '0; op_b = '0; flush = 1'b0; rd_hilo = 1'b0;
        wr_hi = 1'b0; wr_lo = 1'b0; wr_data = '0;
        #1;
        chk("reset_hi", {32'b0, hi}, 64'd0);
        chk("reset_lo", {32'b0, lo}, 64'd0);
        chk("reset_busy", {63'b0, busy}, 64'd0);
        chk("reset_stall", {63'b0, stall}, 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run("mult_m3x5",   1'b1, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'd33);
        run("multu_max",   1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'd33);
        run("div_m7_2",    1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd33);
        run("divu_7_2",    1'b0, 1'b0, 32'd7, 32'd2, 32'd1, 32'd3, 32'd33);
        run("div_ovf",     1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 32'd33);
        run("divu_5_0",    1'b0, 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 32'd1);
        run("div_m9_0",    1'b0, 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 32'd1);

        // Both strobes high: multiply takes priority.
        issue(1'b1, 1'b1, 1'b0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 32'd33);
        retire("both_starts");

        // Result visible to mfhi/mflo right after completion without stall.
        rd_hilo = 1'b1;
        #1;
        chk("rd_after_done_stall", {63'b0, stall}, 64'd0);
        rd_hilo = 1'b0;

        // mflo one cycle after a mult start.
        issue(1'b1, 1'b0, 1'b1, 32'd6, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 32'd33);
        @(negedge clk);
        rd_hilo = 1'b1;
        #1;
        cyc = 0;
        while (stall === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge clk);
            #1;
        end
        chk("stall_cycles", {32'b0, cyc}, 64'd32);
        chk("stall_busy_low", {63'b0, busy}, 64'd0);
        chk("stall_released", {63'b0, stall}, 64'd0);
        e = sb_q.pop_front();
        chk("stall_mult_hi", {32'b0, hi}, {32'b0, e.hi});
        chk("stall_mult_lo", {32'b0, lo}, {32'b0, e.lo});
        rd_hilo = 1'b0;

        @(negedge clk);
        wr_hi = 1'b1; wr_data = 32'h1234;
        @(negedge clk);
        wr_hi = 1'b0;
        chk("mthi", {32'b0, hi}, 64'h1234);

        // Flush mid-divide keeps the old HI/LO.
        load_hilo(32'hA, 32'hB);
        chk("preload_hi", {32'b0, hi}, 64'hA);
        chk("preload_lo", {32'b0, lo}, 64'hB);
        issue(1'b0, 1'b0, 1'b0, 32'd100, 32'd7, 1'b0, '0, '0, '0);
        repeat (9) @(negedge clk);
        chk("flush_pre_busy", {63'b0, busy}, 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'b0, busy}, 64'd0);
        repeat (40) @(negedge clk);
        chk("flush_hi", {32'b0, hi}, 64'hA);
        chk("flush_lo", {32'b0, lo}, 64'hB);

        // Start together with flush in IDLE is ignored.
        @(negedge clk);
        start_mult = 1'b1; op_a = 32'd2; op_b = 32'd2; flush = 1'b1;
        @(negedge clk);
        start_mult = 1'b0; flush = 1'b0;
        chk("flush_start_busy", {63'b0, busy}, 64'd0);

        // Asynchronous reset mid-multiply.
        issue(1'b1, 1'b0, 1'b0, 32'd1000, 32'd1000, 1'b0, '0, '0, '0);
        repeat (19) @(negedge clk);
        #2;
        rst_n = 1'b0;
        rd_hilo = 1'b1;
        #1;
        chk("arst_hi", {32'b0, hi}, 64'd0);
        chk("arst_lo", {32'b0, lo}, 64'd0);
        chk("arst_busy", {63'b0, busy}, 64'd0);
        chk("arst_stall", {63'b0, stall}, 64'd0);
        rd_hilo = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic checked against native arithmetic.
        for (int i = 0; i < 10; i++) begin
            mul = 1'($urandom_range(0, 1));
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = (i == 4) ? 32'd0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            if (i % 4 == 1) b = -b;
            m   = model(mul, sgn, a, b);
            issue(mul, 1'b0, sgn, a, b, 1'b1, m[63:32], m[31:0],
                  (!mul && b == 32'd0) ? 32'd1 : 32'd33);
            retire($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
